lab_rdout_engine: RTL and testbench
===================================

LAB_RDOUT_ENGINE -- requirements
Module: lab_rdout_engine

Interface
REQ-001 Parameter NWORDS, default 1536, SHALL set the number of 32-bit words read per LAB (addresses 0..NWORDS-1).
REQ-002 Parameter RAM_LATENCY, default 1, SHALL set the cycles from lab_addr_o change to valid lab_dat_i (legal values 1 or 2).
REQ-003 Parameter TIMEOUT, default 65535, SHALL set the cycles to wait for lab_done_i before a LAB is declared timed out.
REQ-004 clk_i  input  1  sole clock; all logic on its rising edge.
REQ-005 rst_i  input  1  reset, asynchronous, active-high.
REQ-006 start_i  input  1  single-cycle readout request.
REQ-007 lab_mask_i  input  4  LABs to read; bit n = LAB n.
REQ-008 busy_o  output  1  high from the cycle after an accepted start until the final word handshake.
REQ-009 lab_addr_o  output  13  readout address; [12:11] LAB select, [10:0] word index.
REQ-010 lab_done_i  input  1  digitization-complete flag for the LAB selected by lab_addr_o[12:11].
REQ-011 lab_dat_i  input  32  RAM read data.
REQ-012 m_dat_o  output  32  stream data.
REQ-013 m_valid_o  output  1  stream word valid.
REQ-014 m_ready_i  input  1  downstream accept; transfer when m_valid_o and m_ready_i are both high.
REQ-015 m_last_o  output  1  marks the final word of the event.
REQ-016 err_o  output  1  sticky timeout flag, cleared only by reset or by an accepted start.
REQ-017 evt_cnt_o  output  16  count of completed events.

Function
REQ-018 start_i SHALL be accepted only in IDLE with lab_mask_i nonzero; accepting it latches the mask and clears err_o. A start while busy, or with a zero mask, SHALL be ignored.
REQ-019 The FSM SHALL have the states IDLE, WAIT_DONE, HEADER, READ and NEXT, and SHALL visit the masked LABs in ascending order.
REQ-020 In WAIT_DONE, lab_addr_o SHALL be {lab,11'd0}; the FSM SHALL stay until lab_done_i is sampled high and then go to HEADER.
REQ-021 If TIMEOUT cycles elapse in WAIT_DONE, the block SHALL set err_o, emit a header with the timeout bit set, emit no data for that LAB, and go to NEXT.
REQ-022 Header word layout:
- [31:24] = 8'hA5
- [23:22] = LAB index
- [21] = timeout
- [20:16] = 0
- [15:0] = evt_cnt_o value
REQ-023 In READ, the block SHALL issue addresses 0..NWORDS-1 in order and SHALL emit lab_dat_i words in that same order, with no drops and no duplicates.
REQ-024 An address SHALL be issued only when internal FIFO free entries exceed the reads in flight, so that backpressure never loses data.
REQ-025 With m_ready_i held high, READ SHALL sustain one word per cycle after the initial RAM_LATENCY fill.
REQ-026 m_dat_o and m_last_o SHALL hold stable while m_valid_o is high and m_ready_i is low.
REQ-027 m_last_o SHALL be high only on the final word of the last masked LAB (a data word, or a timeout header).
REQ-028 On the handshake of the m_last_o word, the block SHALL:
- increment evt_cnt_o, wrapping 16'hFFFF to 0;
- drop busy_o on the next cycle;
- return to IDLE.
REQ-029 lab_done_i SHALL be sampled only in WAIT_DONE; if it falls during READ, the fall SHALL be ignored.

Reset
REQ-030 Asserting rst_i SHALL immediately force the following values: state IDLE, busy_o 0, m_valid_o 0, m_last_o 0, m_dat_o 0, lab_addr_o 0, err_o 0, evt_cnt_o 0.
REQ-031 A reset during operation SHALL flush the FIFO and all in-flight reads; the first start after reset SHALL begin with evt_cnt_o = 0.

Structure
REQ-032 A shared package lab_rdout_pkg SHALL hold:
- the state enumeration;
- header magic 8'hA5;
- header field bit positions;
- the default NWORDS.
REQ-033 One sub-module, lab_rdout_fifo (4-deep, first-word-fall-through, with occupancy output), SHALL buffer stream words; the FSM, address counter and timeout counter SHALL stay in lab_rdout_engine.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
- Mask 4'b0001, lab_done_i high, m_ready_i high, RAM model data = address → stream is 0xA5000000 then 0..1535; last asserted on word 1535; evt_cnt_o becomes 1.
- Mask 4'b1010, random m_ready_i at 30% → header LAB1, 1536 words, header LAB3 (0xA5C00000 | evt), 1536 words; exact order; last only on the final word.
- Mask 4'b0100 with lab_done_i never asserted, TIMEOUT=16 → header 0xA5A00000 emitted with m_last_o=1 after 16 cycles; err_o=1.
- Assert rst_i mid-READ at word 700 → outputs zero in the same cycle; the next start yields a complete event with header count 0.
- start_i pulsed while busy, and start_i with mask 0 → no effect; word count unchanged.
- Preload evt_cnt to 0xFFFF via 65535 short events (or a force) → next header [15:0]=0xFFFF; evt_cnt_o wraps to 0.

Source files
------------

// File: rtl/lab_rdout_pkg.sv
// Shared types and constants for the LAB readout engine: FSM states, header
// layout and helpers used by the engine and its stream FIFO.
package lab_rdout_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DONE,
    HEADER,
    READ,
    NEXT
  } state_t;

  localparam logic [7:0] HDR_MAGIC     = 8'hA5;
  localparam int         HDR_MAGIC_LSB = 24;
  localparam int         HDR_LAB_LSB   = 22;
  localparam int         HDR_TMO_BIT   = 21;
  localparam int         HDR_EVT_LSB   = 0;

  localparam int NWORDS_DEF = 1536;
  localparam int FIFO_DEPTH = 4;

  // Lowest set bit of a LAB mask (0 for an empty mask).
  function automatic logic [1:0] first_lab(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (m[i]) r = 2'(i);
    return r;
  endfunction

  function automatic logic [31:0] mk_header(input logic [1:0] lab, input logic tmo,
                                            input logic [15:0] evt);
    logic [31:0] h;
    h = '0;
    h[HDR_MAGIC_LSB +: 8] = HDR_MAGIC;
    h[HDR_LAB_LSB +: 2]   = lab;
    h[HDR_TMO_BIT]        = tmo;
    h[HDR_EVT_LSB +: 16]  = evt;
    return h;
  endfunction

endpackage

// File: rtl/lab_rdout_fifo.sv
// 4-deep first-word-fall-through FIFO with occupancy; the head reads as zero
// when empty so the stream outputs are clean after reset.
module lab_rdout_fifo
  import lab_rdout_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic [2:0]   count
);

  logic [W-1:0] mem [FIFO_DEPTH];
  logic [1:0]   wp, rp;
  logic [2:0]   cnt;
  logic         wr, rd;

  assign wr = push && (cnt != 3'(FIFO_DEPTH));
  assign rd = pop && (cnt != 3'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + 2'd1;
      if (rd) rp <= rp + 2'd1;
      cnt <= cnt + 3'(wr) - 3'(rd);
    end
  end

  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;

  assign valid = (cnt != 3'd0);
  assign dout  = valid ? mem[rp] : '0;
  assign count = cnt;

endmodule

// File: rtl/lab_rdout_engine.sv
// LAB readout engine: waits for each masked LAB to finish digitizing, then
// streams a header plus NWORDS RAM words per LAB through a small FIFO.
module lab_rdout_engine
  import lab_rdout_pkg::*;
#(
  parameter int NWORDS      = NWORDS_DEF,
  parameter int RAM_LATENCY = 1,
  parameter int TIMEOUT     = 65535
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [3:0]  lab_mask_i,
  output logic        busy_o,
  output logic [12:0] lab_addr_o,
  input  logic        lab_done_i,
  input  logic [31:0] lab_dat_i,
  output logic [31:0] m_dat_o,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic        m_last_o,
  output logic        err_o,
  output logic [15:0] evt_cnt_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t          state, state_nxt;
  logic [3:0]      mask_r, rest;
  logic [1:0]      lab;
  logic [10:0]     widx;
  logic [TW-1:0]   tmo_cnt;
  logic            tmo_flag;
  logic [15:0]     evt_cnt;
  logic [RAM_LATENCY:0] vld_pipe, last_pipe;
  logic [2:0]      inflight;
  logic [3:0]      room;
  logic            f_push, f_valid, hs, last_hs;
  logic [32:0]     f_din, f_dout;
  logic [2:0]      f_cnt;
  logic            last_lab, can_issue, last_issue, hdr_push, done_hit, tmo_hit, accept;

  always_comb begin
    inflight = '0;
    for (int i = 0; i <= RAM_LATENCY; i++) inflight += 3'(vld_pipe[i]);
  end

  // Entries left after this edge: a pop this cycle frees one, and every read
  // already in flight has a reserved slot, so backpressure can never overflow.
  assign hs         = f_valid && m_ready_i;
  assign last_hs    = hs && f_dout[32];
  assign room       = 4'(FIFO_DEPTH) - 4'(f_cnt) + 4'(hs);
  assign rest       = mask_r & ~(4'b0001 << lab);
  assign last_lab   = (rest == 4'd0);
  assign accept     = (state == IDLE) && start_i && (lab_mask_i != 4'd0);
  assign can_issue  = (state == READ) && (room > 4'(inflight));
  assign last_issue = can_issue && (widx == 11'(NWORDS - 1));
  // Header waits for the previous LAB's reads to land so stream order holds.
  assign hdr_push   = (state == HEADER) && (inflight == 3'd0) && (room != 4'd0);
  assign done_hit   = (state == WAIT_DONE) && lab_done_i;
  assign tmo_hit    = (state == WAIT_DONE) && !lab_done_i && (tmo_cnt == TW'(TIMEOUT - 1));

  assign f_push = vld_pipe[RAM_LATENCY] || hdr_push;
  assign f_din  = vld_pipe[RAM_LATENCY] ? {last_pipe[RAM_LATENCY], lab_dat_i}
                                        : {tmo_flag && last_lab, mk_header(lab, tmo_flag, evt_cnt)};

  lab_rdout_fifo #(.W(33)) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (f_push),
    .din   (f_din),
    .pop   (m_ready_i),
    .dout  (f_dout),
    .valid (f_valid),
    .count (f_cnt)
  );

  assign m_valid_o = f_valid;
  assign m_dat_o   = f_dout[31:0];
  assign m_last_o  = f_dout[32];
  assign evt_cnt_o = evt_cnt;

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept) state_nxt = WAIT_DONE;
      WAIT_DONE: if (done_hit || tmo_hit) state_nxt = HEADER;
      HEADER:    if (hdr_push) state_nxt = tmo_flag ? NEXT : READ;
      READ:      if (last_issue) state_nxt = NEXT;
      NEXT:      if (!last_lab) state_nxt = WAIT_DONE;
                 else if (last_hs) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mask_r     <= '0;
      lab        <= '0;
      widx       <= '0;
      tmo_cnt    <= '0;
      tmo_flag   <= 1'b0;
      evt_cnt    <= '0;
      vld_pipe   <= '0;
      last_pipe  <= '0;
      busy_o     <= 1'b0;
      err_o      <= 1'b0;
      lab_addr_o <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[RAM_LATENCY-1:0], can_issue};
      last_pipe <= {last_pipe[RAM_LATENCY-1:0], last_issue && last_lab};
      if (last_hs) begin
        evt_cnt <= evt_cnt + 16'd1;
        busy_o  <= 1'b0;
      end
      case (state)
        IDLE: if (accept) begin
          mask_r     <= lab_mask_i;
          lab        <= first_lab(lab_mask_i);
          lab_addr_o <= {first_lab(lab_mask_i), 11'd0};
          tmo_cnt    <= '0;
          err_o      <= 1'b0;
          busy_o     <= 1'b1;
        end
        WAIT_DONE: begin
          tmo_cnt <= tmo_cnt + TW'(1);
          widx    <= '0;
          if (done_hit) tmo_flag <= 1'b0;
          else if (tmo_hit) begin
            tmo_flag <= 1'b1;
            err_o    <= 1'b1;
          end
        end
        READ: if (can_issue) begin
          lab_addr_o <= {lab, widx};
          widx       <= widx + 11'd1;
        end
        NEXT: if (!last_lab) begin
          mask_r     <= rest;
          lab        <= first_lab(rest);
          lab_addr_o <= {first_lab(rest), 11'd0};
          tmo_cnt    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lab_rdout_engine.sv
// Directed bench for lab_rdout_engine: RAM model returns its address, each
// scenario collects the stream and compares against hand-built expectations.
module tb_lab_rdout_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  lab_mask = 4'd0;
  logic        busy;
  logic [12:0] lab_addr;
  logic        lab_done;
  logic [31:0] lab_dat;
  logic [31:0] m_dat;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        m_last;
  logic        err;
  logic [15:0] evt_cnt;

  logic [3:0]  done_en = 4'hF;
  logic [31:0] ram_q = '0;
  int          cyc = 0;

  int errs = 0;
  int checks = 0;
  int t_start = 0;
  int unstable = 0;

  logic [31:0] got_q[$];
  logic        got_last_q[$];
  int          stamp_q[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) ram_q <= {19'd0, lab_addr};
  assign lab_dat  = ram_q;
  assign lab_done = done_en[lab_addr[12:11]];

  lab_rdout_engine #(.NWORDS(1536), .RAM_LATENCY(1), .TIMEOUT(16)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .lab_mask_i (lab_mask),
    .busy_o     (busy),
    .lab_addr_o (lab_addr),
    .lab_done_i (lab_done),
    .lab_dat_i  (lab_dat),
    .m_dat_o    (m_dat),
    .m_valid_o  (m_valid),
    .m_ready_i  (m_ready),
    .m_last_o   (m_last),
    .err_o      (err),
    .evt_cnt_o  (evt_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic do_start(input logic [3:0] m);
    @(negedge clk);
    start    = 1'b1;
    lab_mask = m;
    t_start  = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Collect handshaken words until m_last (or limit words), within budget cycles.
  task automatic collect(input int pct, input int budget, input int limit,
                         input int pulse_at, output bit ok);
    logic hold = 1'b0;
    logic [31:0] pd = '0;
    logic pl = 1'b0;
    ok = 1'b0;
    got_q.delete(); got_last_q.delete(); stamp_q.delete();
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (c == pulse_at) begin start = 1'b1; lab_mask = 4'hF; end
      else if (c == pulse_at + 1) start = 1'b0;
      if (hold && (m_dat !== pd || m_last !== pl)) unstable++;
      m_ready = ($urandom_range(0, 99) < pct);
      hold = m_valid && !m_ready;
      pd = m_dat;
      pl = m_last;
      if (m_valid && m_ready) begin
        got_q.push_back(m_dat);
        got_last_q.push_back(m_last);
        stamp_q.push_back(cyc);
        if ((limit == 0 && m_last) || (limit != 0 && got_q.size() == limit)) begin
          ok = 1'b1;
          break;
        end
      end
    end
    start   = 1'b0;
    m_ready = 1'b1;
  endtask

  task automatic add_lab(input logic [1:0] lab, input logic [15:0] evt);
    exp_q.push_back(32'hA500_0000 | ({30'd0, lab} << 22) | {16'd0, evt});
    for (int i = 0; i < 1536; i++) exp_q.push_back({19'd0, lab, 11'(i)});
  endtask

  function automatic int first_diff();
    int n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (got_q[i] !== exp_q[i]) return i;
    return (got_q.size() == exp_q.size()) ? -1 : n;
  endfunction

  // 1 when exactly one m_last was seen and it was on the final word.
  function automatic logic last_ok();
    int n = 0;
    foreach (got_last_q[i]) if (got_last_q[i]) n++;
    return (n == 1) && (got_last_q.size() > 0) && got_last_q[got_last_q.size()-1];
  endfunction

  initial begin
    bit ok;
    int lat;

    // reset state
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_dat", m_dat, 0);
    chk("rst_addr", lab_addr, 0);
    chk("rst_err", err, 0);
    chk("rst_evt", evt_cnt, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // S1: single LAB, full throughput
    exp_q.delete(); add_lab(2'd0, 16'd0);
    do_start(4'b0001);
    chk("s1_busy", busy, 1);
    collect(100, 3000, 0, -10, ok);
    chk("s1_done", ok, 1);
    chk("s1_len", got_q.size(), 1537);
    chk("s1_hdr", got_q.size() > 0 ? got_q[0] : 32'hx, 32'hA500_0000);
    chk("s1_order", first_diff(), -1);
    chk("s1_last", last_ok(), 1);
    chk("s1_rate", got_q.size() == 1537 ? stamp_q[1536] - stamp_q[1] : -1, 1535);
    @(negedge clk);
    chk("s1_evt", evt_cnt, 1);
    chk("s1_idle", busy, 0);

    // S2: LABs 1 and 3 with 30% ready
    exp_q.delete(); add_lab(2'd1, 16'd1); add_lab(2'd3, 16'd1);
    unstable = 0;
    do_start(4'b1010);
    collect(30, 30000, 0, -10, ok);
    chk("s2_done", ok, 1);
    chk("s2_len", got_q.size(), 3074);
    chk("s2_hdr3", got_q.size() > 1537 ? got_q[1537] : 32'hx, 32'hA5C0_0001);
    chk("s2_order", first_diff(), -1);
    chk("s2_last", last_ok(), 1);
    chk("s2_stable", unstable, 0);
    @(negedge clk);
    chk("s2_evt", evt_cnt, 2);

    // S3: LAB 2 never done -> timeout header only
    done_en = 4'b1011;
    do_start(4'b0100);
    collect(100, 200, 0, -10, ok);
    chk("s3_done", ok, 1);
    chk("s3_len", got_q.size(), 1);
    chk("s3_hdr", got_q.size() > 0 ? got_q[0] : 32'hx, 32'hA5A0_0002);
    chk("s3_lastflag", got_last_q.size() > 0 ? got_last_q[0] : 1'bx, 1);
    lat = (stamp_q.size() > 0) ? stamp_q[0] - t_start : 0;
    chk("s3_latency", (lat >= 17 && lat <= 20), 1);
    @(negedge clk);
    chk("s3_err", err, 1);
    chk("s3_evt", evt_cnt, 3);
    done_en = 4'hF;

    // S4: reset mid-READ after data word 700, then a clean event
    do_start(4'b0001);
    chk("s4_errclr", err, 0);
    collect(100, 3000, 701, -10, ok);
    chk("s4_reach700", ok, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("s4_rst_valid", m_valid, 0);
    chk("s4_rst_last", m_last, 0);
    chk("s4_rst_dat", m_dat, 0);
    chk("s4_rst_addr", lab_addr, 0);
    chk("s4_rst_busy", busy, 0);
    chk("s4_rst_evt", evt_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete(); add_lab(2'd0, 16'd0);
    do_start(4'b0001);
    collect(100, 3000, 0, -10, ok);
    chk("s4_done", ok, 1);
    chk("s4_order", first_diff(), -1);
    chk("s4_last", last_ok(), 1);
    @(negedge clk);
    chk("s4_evt", evt_cnt, 1);

    // S5: zero-mask start and start while busy are ignored
    do_start(4'b0000);
    repeat (5) @(negedge clk);
    chk("s5_mask0_busy", busy, 0);
    chk("s5_mask0_valid", m_valid, 0);
    chk("s5_mask0_evt", evt_cnt, 1);
    exp_q.delete(); add_lab(2'd0, 16'd1);
    do_start(4'b0001);
    collect(100, 3000, 0, 50, ok);
    chk("s5_done", ok, 1);
    chk("s5_order", first_diff(), -1);
    repeat (20) @(negedge clk);
    chk("s5_busy", busy, 0);
    chk("s5_valid", m_valid, 0);
    chk("s5_evt", evt_cnt, 2);

    // S6: event count wrap
    force dut.evt_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.evt_cnt;
    @(negedge clk);
    chk("s6_preload", evt_cnt, 16'hFFFF);
    exp_q.delete(); add_lab(2'd0, 16'hFFFF);
    do_start(4'b0001);
    collect(100, 3000, 0, -10, ok);
    chk("s6_done", ok, 1);
    chk("s6_hdr", got_q.size() > 0 ? got_q[0] : 32'hx, 32'hA500_FFFF);
    chk("s6_order", first_diff(), -1);
    @(negedge clk);
    chk("s6_wrap", evt_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
